// File: rtl/morse_decoder_pkg.sv
// Shared Morse timing constants, FSM state encoding and the per-character
// symbol accumulator type.
package morse_decoder_pkg;

    // Durations are counted in Morse units (ticks of the prescaler).
    localparam logic [2:0] DASH_UNITS     = 3'd2;
    localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
    localparam logic [2:0] WORD_GAP_UNITS = 3'd7;
    localparam logic [2:0] DUR_MAX        = 3'd7;
    localparam logic [2:0] MAX_SYMBOLS    = 3'd5;
    localparam logic [7:0] ASCII_SPACE    = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_WORD_GAP
    } state_t;

    // Symbols left-aligned, MSB first: dot = 0, dash = 1.
    typedef struct packed {
        logic [4:0] pattern;
        logic [2:0] length;
        logic       overflow;
    } char_buf_t;

endpackage

// File: rtl/morse_to_ascii_lut.sv
// Combinational International Morse lookup: left-aligned pattern plus length
// to uppercase ASCII letter or digit.
module morse_to_ascii_lut (
    input  logic [4:0] pattern,
    input  logic [2:0] length,
    output logic [7:0] ascii,
    output logic       valid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        ascii = 8'h00;
        valid = 1'b1;
        case ({length, pattern})
            {3'd2, 5'b01000}: ascii = "A";
            {3'd4, 5'b10000}: ascii = "B";
            {3'd4, 5'b10100}: ascii = "C";
            {3'd3, 5'b10000}: ascii = "D";
            {3'd1, 5'b00000}: ascii = "E";
            {3'd4, 5'b00100}: ascii = "F";
            {3'd3, 5'b11000}: ascii = "G";
            {3'd4, 5'b00000}: ascii = "H";
            {3'd2, 5'b00000}: ascii = "I";
            {3'd4, 5'b01110}: ascii = "J";
            {3'd3, 5'b10100}: ascii = "K";
            {3'd4, 5'b01000}: ascii = "L";
            {3'd2, 5'b11000}: ascii = "M";
            {3'd2, 5'b10000}: ascii = "N";
            {3'd3, 5'b11100}: ascii = "O";
            {3'd4, 5'b01100}: ascii = "P";
            {3'd4, 5'b11010}: ascii = "Q";
            {3'd3, 5'b01000}: ascii = "R";
            {3'd3, 5'b00000}: ascii = "S";
            {3'd1, 5'b10000}: ascii = "T";
            {3'd3, 5'b00100}: ascii = "U";
            {3'd4, 5'b00010}: ascii = "V";
            {3'd3, 5'b01100}: ascii = "W";
            {3'd4, 5'b10010}: ascii = "X";
            {3'd4, 5'b10110}: ascii = "Y";
            {3'd4, 5'b11000}: ascii = "Z";
            {3'd5, 5'b11111}: ascii = "0";
            {3'd5, 5'b01111}: ascii = "1";
            {3'd5, 5'b00111}: ascii = "2";
            {3'd5, 5'b00011}: ascii = "3";
            {3'd5, 5'b00001}: ascii = "4";
            {3'd5, 5'b00000}: ascii = "5";
            {3'd5, 5'b10000}: ascii = "6";
            {3'd5, 5'b11000}: ascii = "7";
            {3'd5, 5'b11100}: ascii = "8";
            {3'd5, 5'b11110}: ascii = "9";
            default:          valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder: synchronizes the key, times marks and spaces in units,
// and emits decoded characters, word spaces or error pulses.
module morse_decoder
    import morse_decoder_pkg::*;
#(
    parameter int CLKS_PER_UNIT = 2_500_000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Key,
    output logic [7:0] o_ASCII,
    output logic       o_DV,
    output logic       o_Error
);

    localparam int PW = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLKS_PER_UNIT - 1);

    logic          key_meta, key_sync, key_prev;
    logic [PW-1:0] prescale;
    logic [2:0]    dur;
    state_t        state;
    char_buf_t     chr;
    logic [7:0]    lut_ascii;
    logic          lut_valid;

    logic          key_edge, rise, fall, tick;
    logic          is_dash, char_end, word_end;
    logic [2:0]    dur_eff;

    morse_to_ascii_lut u_lut (
        .pattern (chr.pattern),
        .length  (chr.length),
        .ascii   (lut_ascii),
        .valid   (lut_valid)
    );

    assign key_edge = key_sync ^ key_prev;
    assign rise     = key_edge & key_sync;
    assign fall     = key_edge & ~key_sync;
    assign tick     = (prescale == PRESCALE_LAST);

    // Duration including a tick landing in this very cycle, so an edge that
    // coincides with a unit boundary sees the full unit count.
    assign dur_eff  = (tick && dur != DUR_MAX) ? dur + 3'd1 : dur;
    assign is_dash  = (dur_eff >= DASH_UNITS);
    assign char_end = tick && (dur_eff == CHAR_GAP_UNITS);
    assign word_end = tick && (dur_eff == WORD_GAP_UNITS);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
            key_prev <= 1'b0;
            prescale <= '0;
            dur      <= '0;
            state    <= ST_IDLE;
            chr      <= '0;
            o_ASCII  <= 8'h00;
            o_DV     <= 1'b0;
            o_Error  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            key_meta <= i_Key;
            key_sync <= key_meta;
            key_prev <= key_sync;

            prescale <= (key_edge || tick) ? '0 : prescale + PW'(1);

            if (key_edge)
                dur <= '0;
            else if (tick && dur != DUR_MAX)
                dur <= dur + 3'd1;

            o_ASCII <= 8'h00;
            o_DV    <= 1'b0;
            o_Error <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rise)
                        state <= ST_MARK;
                end
                ST_MARK: begin
                    if (fall) begin
                        if (chr.length == MAX_SYMBOLS) begin
                            chr.overflow <= 1'b1;
                        end else begin
                            chr.pattern[3'd4 - chr.length] <= is_dash;
                            chr.length <= chr.length + 3'd1;
                        end
                        state <= ST_SPACE;
                    end
                end
                ST_SPACE: begin
                    if (char_end) begin
                        if (!chr.overflow && lut_valid) begin
                            o_DV    <= 1'b1;
                            o_ASCII <= lut_ascii;
                        end else begin
                            o_Error <= 1'b1;
                        end
                        chr   <= '0;
                        state <= rise ? ST_MARK : ST_WORD_GAP;
                    end else if (rise) begin
                        state <= ST_MARK;
                    end
                end
                ST_WORD_GAP: begin
                    if (word_end) begin
                        o_DV    <= 1'b1;
                        o_ASCII <= ASCII_SPACE;
                        state   <= rise ? ST_MARK : ST_IDLE;
                    end else if (rise) begin
                        state <= ST_MARK;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: a cycle-timed reference model built from symbol
// strings and key timing, checked against the outputs on every cycle.
module tb_morse_decoder;

    localparam int N = 4;

    logic       i_Clk   = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Key   = 1'b0;
    logic [7:0] o_ASCII;
    logic       o_DV;
    logic       o_Error;

    morse_decoder #(.CLKS_PER_UNIT(N)) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Key   (i_Key),
        .o_ASCII (o_ASCII),
        .o_DV    (o_DV),
        .o_Error (o_Error)
    );

    always #5 i_Clk = ~i_Clk;

    int cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    // Reference model: expected output per cycle (ASCII code, or -1 for error).
    string morse_tab[36];
    string char_tab = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    int    exp_ev[int];
    string syms = "";
    int    press_cyc = 0;
    int    rel_cyc = 0;
    int    seen[$];
    int    seen_cyc[$];
    bit    checking = 1'b0;
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int lookup(string s);
        if (s.len() > 5) return -1;
        for (int i = 0; i < 36; i++)
            if (morse_tab[i] == s) return int'(char_tab[i]);
        return -1;
    endfunction

    task automatic drop_after(int limit);
        int gone[$];
        foreach (exp_ev[k]) if (k > limit) gone.push_back(k);
        foreach (gone[i]) exp_ev.delete(gone[i]);
    endtask

    // Drivers run at posedge+1; an edge driven at cycle c is acted on at c+3.
    task automatic key_down();
        drop_after(cyc + 3);
        if (syms.len() > 0 && cyc - rel_cyc >= 3 * N) syms = "";
        i_Key = 1'b1;
        press_cyc = cyc;
    endtask

    task automatic key_up();
        syms = {syms, (cyc - press_cyc >= 2 * N) ? "-" : "."};
        i_Key = 1'b0;
        rel_cyc = cyc;
        exp_ev[cyc + 3 * N + 3] = lookup(syms);
        exp_ev[cyc + 7 * N + 3] = 32'h20;
    endtask

    task automatic tick_wait(int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic press(int mark, int gap);
        key_down();
        tick_wait(mark);
        key_up();
        tick_wait(gap);
    endtask

    task automatic do_reset();
        drop_after(cyc);
        syms = "";
        i_Reset = 1'b1;
        tick_wait(1);
        i_Reset = 1'b0;
        press_cyc = cyc;
    endtask

    task automatic settle();
        tick_wait(8 * N + 8);
    endtask

    // '!' in the expected string stands for an error pulse.
    task automatic expect_seen(string name, string s);
        check({name, " count"}, seen.size(), s.len());
        for (int i = 0; i < s.len() && i < seen.size(); i++)
            check({name, " char"}, seen[i], (s[i] == 8'h21) ? -1 : int'(s[i]));
        seen.delete();
        seen_cyc.delete();
    endtask

    always @(negedge i_Clk) begin : compare
        int e;
        if (checking) begin
            e = exp_ev.exists(cyc) ? exp_ev[cyc] : -2;
            check("o_DV", int'(o_DV), (e >= 0) ? 1 : 0);
            check("o_Error", int'(o_Error), (e == -1) ? 1 : 0);
            check("o_ASCII", int'(o_ASCII), (e >= 0) ? e : 0);
            if (o_DV) begin
                seen.push_back(int'(o_ASCII));
                seen_cyc.push_back(cyc);
            end
            if (o_Error) begin
                seen.push_back(-1);
                seen_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        int r, nsym, mark, gap;
        string all_chars;
        morse_tab = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                      ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                      "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                      "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                      "--...", "---..", "----."};

        tick_wait(3);
        i_Reset = 1'b0;
        check("reset o_DV", int'(o_DV), 0);
        check("reset o_Error", int'(o_Error), 0);
        check("reset o_ASCII", int'(o_ASCII), 0);
        checking = 1'b1;
        tick_wait(2);

        // Single dot: 'E' after the character gap, space after the word gap.
        press(N, 8 * N);
        r = rel_cyc;
        if (seen_cyc.size() >= 2) begin
            check("E latency", seen_cyc[0] - r, 3 * N + 3);
            check("space latency", seen_cyc[1] - r, 7 * N + 3);
        end
        settle();
        expect_seen("E", "E ");

        press(N, N);
        press(3 * N, 3 * N);
        settle();
        expect_seen("A", "A ");

        press(2 * N, 3 * N);
        settle();
        expect_seen("T", "T ");

        press(12 * N, 3 * N);
        settle();
        expect_seen("long hold", "T ");

        for (int i = 0; i < 5; i++) press(3 * N, (i == 4) ? 3 * N : N);
        settle();
        expect_seen("five dashes", "0 ");

        // Reset inside the word gap suppresses the space after an error.
        for (int i = 0; i < 6; i++) press(3 * N, (i == 5) ? 4 * N : N);
        do_reset();
        tick_wait(2);
        expect_seen("six dashes", "!");

        press(N, N); press(N, N); press(3 * N, N); press(3 * N, 4 * N);
        do_reset();
        tick_wait(2);
        expect_seen("..--", "!");

        press(N, N); press(N, N);
        do_reset();
        tick_wait(2);
        press(3 * N, 4 * N);
        do_reset();
        tick_wait(2);
        expect_seen("reset discard", "T");

        key_down();
        tick_wait(N);
        do_reset();
        tick_wait(3 * N);
        key_up();
        settle();
        expect_seen("held through reset", "T ");

        // Round trip over the whole alphabet and digits.
        for (int c = 0; c < 36; c++)
            for (int s = 0; s < morse_tab[c].len(); s++)
                press((morse_tab[c][s] == 8'h2d) ? 3 * N : N,
                      (s == morse_tab[c].len() - 1) ? 3 * N : N);
        settle();
        all_chars = {char_tab, " "};
        expect_seen("round trip", all_chars);

        // Random marks and gaps in cycles, straddling every threshold.
        for (int n = 0; n < 120; n++) begin
            nsym = $urandom_range(1, 6);
            for (int s = 0; s < nsym; s++) begin
                if ($urandom_range(0, 1) == 1) mark = $urandom_range(2 * N, 6 * N);
                else                           mark = $urandom_range(1, 2 * N - 1);
                if (s == nsym - 1) gap = $urandom_range(3 * N, 9 * N);
                else               gap = $urandom_range(1, 3 * N - 1);
                press(mark, gap);
            end
        end
        settle();
        seen.delete();
        seen_cyc.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 The block SHALL have parameter CLKS_PER_UNIT, default 2_500_000, giving clock cycles per Morse time unit (100 ms at 25 MHz).
REQ-002 i_Clk  input  1  single clock for all logic, rising edge.
REQ-003 i_Reset  input  1  synchronous, active-high reset.
REQ-004 i_Key  input  1  asynchronous, externally debounced key level; 1 = key down (mark), 0 = key up (space).
REQ-005 o_ASCII  output  8  decoded character, valid only while o_DV=1.
REQ-006 o_DV  output  1  one-cycle pulse when o_ASCII holds a decoded character or word space.
REQ-007 o_Error  output  1  one-cycle pulse when a completed character is undecodable.

Function
REQ-008 i_Key SHALL pass through a 2-flop synchronizer; all timing refers to the synchronized key (2-cycle latency).
REQ-009 Prescaler SHALL emit one unit tick every CLKS_PER_UNIT cycles, restarting from 0 on every synchronized key edge.
REQ-010 Duration counter SHALL count ticks since the last key edge, clear on each edge, and saturate at 7.
REQ-011 FSM states: IDLE, MARK, SPACE, WORD_GAP; reset state IDLE.
REQ-012 IDLE: key down -> MARK; otherwise remain in IDLE, emit nothing.
REQ-013 MARK: on key release, classify symbol: duration <2 ticks -> dot (0), >=2 -> dash (1); -> SPACE.
REQ-014 Symbols SHALL be stored MSB-first, left-aligned in a 5-bit pattern (symbol n at bit 4-n), with a 3-bit length; 'A' = 01000/len 2, '0' = 11111/len 5.
REQ-015 A sixth or later symbol SHALL set a sticky overflow flag; pattern and length remain at their 5-symbol values.
REQ-016 SPACE: key down before 3 ticks -> MARK (same character); duration reaching 3 ticks -> end of character, -> WORD_GAP.
REQ-017 End of character: if overflow clear and lookup valid, o_DV=1 with o_ASCII for one cycle; otherwise o_Error=1, o_DV=0; pattern, length and overflow SHALL clear in the same cycle.
REQ-018 Lookup SHALL cover A-Z (uppercase, 0x41-0x5A) and 0-9 (0x30-0x39) per International Morse; every other pattern/length combination is invalid.
REQ-019 WORD_GAP: key down -> MARK (new character, no space emitted); duration reaching 7 ticks (measured from the last release) -> o_DV=1, o_ASCII=0x20 for one cycle, -> IDLE.
REQ-020 o_DV and o_Error SHALL be registered and assert in the cycle after the tick that triggers them; they SHALL never be high together.
REQ-021 A key held indefinitely in MARK SHALL be classified as a dash on release; no output occurs while held.
REQ-022 o_ASCII SHALL hold 0x00 whenever o_DV=0.

Reset
REQ-023 On i_Reset=1 at a clock edge: state IDLE; prescaler, duration, pattern, length, overflow cleared; synchronizer flops 0; o_ASCII=0x00, o_DV=0, o_Error=0.
REQ-024 Reset mid-character SHALL discard the partial character without any o_DV or o_Error pulse.
REQ-025 Key held down when reset releases SHALL be treated as a fresh edge: MARK is entered once the synchronized key reads 1.

Structure
REQ-026 Timing constants (dash threshold 2, character gap 3, word gap 7 units), the ASCII space code, and FSM state encodings SHALL live in a shared package/header used by both encoder and decoder benches.
REQ-027 The pattern/length-to-ASCII lookup SHALL be a separate combinational sub-module, morse_to_ascii_lut (inputs pattern[4:0], length[2:0]; outputs ascii[7:0], valid).

Verification (CLKS_PER_UNIT=4)
REQ-028 Press 1 unit, release 8 units -> o_DV with 0x45 ('E') 3 units after release, then o_DV with 0x20 7 units after release; no o_Error.
REQ-029 Press 1, gap 1, press 3, gap 3 -> single o_DV with 0x41 ('A'); a 1-unit dot versus a 2-unit press yields 'E' versus 'T' (0x54).
REQ-030 Five 3-unit dashes separated by 1-unit gaps -> 0x30; six such dashes -> one o_Error pulse, no o_DV.
REQ-031 Pattern dot-dot-dash-dash (00110/len 4) -> o_Error, o_DV stays 0.
REQ-032 Two dots, i_Reset for 1 cycle, then one dash and 3-unit gap -> only o_DV with 0x54; no pulse from the discarded dots.
REQ-033 Round trip: all 36 characters driven through the existing ASCII-to-Morse encoder and a timing generator -> decoder returns the uppercase character for each, in order.
